updown_step_ctrl: RTL and testbench



---
 rtl/updown_pkg.sv | 18 +
 rtl/btn_debounce.sv | 46 ++++
 rtl/updown_step_ctrl.sv | 103 ++++++++++
 tb/tb_updown_step_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/updown_pkg.sv
// updown_pkg: step FSM states and default timing constants shared by the up/down counter front end
package updown_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } step_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_HOLD_CYCLES     = 500;
  localparam int DEF_REPEAT_CYCLES   = 100;

  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, stability-count debouncer and rising-edge flag for one raw button
module btn_debounce
  import updown_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic Clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1, s2, level_q;
  logic [CW-1:0] cnt;

  // bring the asynchronous button into the Clk domain
  always_ff @(posedge Clk) begin
    s1 <= !reset ? 1'b0 : btn;
    s2 <= !reset ? 1'b0 : s1;
  end

  // accept a new level only after it has disagreed with the current one for DEBOUNCE_CYCLES cycles
  always_ff @(posedge Clk) begin
    if (!reset) begin
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      level_q <= level;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/updown_step_ctrl.sv
// updown_step_ctrl: conditions the direction and step buttons into UpOrDown and an auto-repeating step_pulse
module updown_step_ctrl
  import updown_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       btn_dir,
  input  logic       btn_step,
  output logic       UpOrDown,
  output logic       step_pulse,
  output logic [1:0] step_state
);

  localparam int TW = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES));

  logic          dir_level, dir_rise, step_level, step_rise, pulse_n;
  logic [TW-1:0] timer, timer_n;
  step_state_t   state, state_n;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir (
    .Clk  (Clk),
    .reset(reset),
    .btn  (btn_dir),
    .level(dir_level),
    .rise (dir_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .Clk  (Clk),
    .reset(reset),
    .btn  (btn_step),
    .level(step_level),
    .rise (step_rise)
  );

  // next step state, timer and pulse; the timer restarts on every pulse so it never wraps
  always_comb begin
    state_n = state;
    timer_n = timer;
    pulse_n = 1'b0;
    case (state)
      IDLE: begin
        if (step_rise) begin
          pulse_n = 1'b1;
          timer_n = '0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (!step_level) begin
          timer_n = '0;
          state_n = IDLE;
        end else if (timer == TW'(HOLD_CYCLES - 1)) begin
          pulse_n = 1'b1;
          timer_n = '0;
          state_n = REPEAT;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      REPEAT: begin
        if (!step_level) begin
          timer_n = '0;
          state_n = IDLE;
        end else if (timer == TW'(REPEAT_CYCLES - 1)) begin
          pulse_n = 1'b1;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: begin
        timer_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  // step FSM state, timer and registered pulse
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state      <= IDLE;
      timer      <= '0;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      step_pulse <= pulse_n;
    end
  end

  // every direction press flips the count direction; a press implies the level is already high
  always_ff @(posedge Clk) begin
    UpOrDown <= !reset ? 1'b1 : UpOrDown ^ (dir_rise & dir_level);
  end

  assign step_state = state;

endmodule

// File: tb/tb_updown_step_ctrl.sv
// tb_updown_step_ctrl: table vectors, hand corner sequences and random stimulus against a behavioural model
module tb_updown_step_ctrl;

  localparam int D = 4;
  localparam int H = 8;
  localparam int R = 3;

  logic       Clk = 1'b0, reset = 1'b0, btn_dir = 1'b0, btn_step = 1'b0;
  logic       UpOrDown, step_pulse;
  logic [1:0] step_state;

  int vectors = 0, miscompares = 0, cyc = 0;

  updown_step_ctrl #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .btn_dir   (btn_dir),
    .btn_step  (btn_step),
    .UpOrDown  (UpOrDown),
    .step_pulse(step_pulse),
    .step_state(step_state)
  );

  always #5 Clk = ~Clk;

  // behavioural model: raw samples reach the debouncer two edges late, a level flips once the
  // last D synchronised samples all disagree with it, pulses fall at press, press+H, +R, +R ...
  bit       rawd[2][2];
  bit       win[2][D];
  int       seen[2];
  bit       lvl[2], lvlp[2];
  bit       armed, m_up, m_pulse;
  int       elapsed, m_state;
  logic [3:0] cnt4;

  task automatic model_edge(input bit r, input bit d, input bit s);
    bit raw[2], lv[2], lvp[2], sy[2], allmis;
    raw[0] = d;
    raw[1] = s;
    if (!r) begin
      for (int b = 0; b < 2; b++) begin
        rawd[b][0] = 1'b0;
        rawd[b][1] = 1'b0;
        seen[b]    = 0;
        lvl[b]     = 1'b0;
        lvlp[b]    = 1'b0;
      end
      armed   = 1'b0;
      elapsed = 0;
      m_up    = 1'b1;
      m_pulse = 1'b0;
      m_state = 0;
      return;
    end
    for (int b = 0; b < 2; b++) begin
      lv[b]      = lvl[b];
      lvp[b]     = lvlp[b];
      sy[b]      = rawd[b][1];
      rawd[b][1] = rawd[b][0];
      rawd[b][0] = raw[b];
    end
    if (lv[0] && !lvp[0]) m_up = !m_up;
    m_pulse = 1'b0;
    if (!armed) begin
      if (lv[1] && !lvp[1]) begin
        armed   = 1'b1;
        elapsed = 0;
        m_pulse = 1'b1;
      end
    end else if (!lv[1]) begin
      armed = 1'b0;
    end else begin
      elapsed++;
      m_pulse = elapsed >= H && (elapsed - H) % R == 0;
    end
    m_state = !armed ? 0 : elapsed < H ? 1 : 2;
    for (int b = 0; b < 2; b++) begin
      for (int i = D - 1; i > 0; i--) win[b][i] = win[b][i-1];
      win[b][0] = sy[b];
      seen[b]++;
      allmis = seen[b] >= D;
      for (int i = 0; i < D; i++) if (win[b][i] == lv[b]) allmis = 1'b0;
      lvlp[b] = lv[b];
      if (allmis) lvl[b] = !lv[b];
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // one clock: drive inputs, let the edge happen, update the model, compare 1ns later
  task automatic cycle(input bit r, input bit d, input bit s);
    bit pp, pu;
    reset    = r;
    btn_dir  = d;
    btn_step = s;
    pp = step_pulse === 1'b1;
    pu = UpOrDown === 1'b1;
    @(posedge Clk);
    model_edge(r, d, s);
    if (!r) cnt4 = 4'd0;
    else if (pp) cnt4 = pu ? cnt4 + 4'd1 : cnt4 - 4'd1;
    #1;
    check("UpOrDown", 32'(UpOrDown), 32'(m_up));
    check("step_pulse", 32'(step_pulse), 32'(m_pulse));
    check("step_state", 32'(step_state), 32'(m_state));
    check("pulse_back_to_back", 32'(pp && step_pulse === 1'b1), 32'd0);
    cyc++;
    @(negedge Clk);
  endtask

  typedef struct {
    bit       r, d, s;
    bit       up, pulse;
    bit [1:0] st;
  } vec_t;

  vec_t tbl[23];
  int   got[$], exp_q[$];
  int   np, first, o;
  bit   rd, rs, rr;
  int   len;

  initial begin
    for (int i = 0; i < 23; i++) begin
      tbl[i].r     = i >= 2;
      tbl[i].d     = i < 2 ? 1'(i % 2) : 1'b0;
      tbl[i].s     = i < 2 ? 1'((i + 1) % 2) : (i >= 10 && i <= 14);
      tbl[i].up    = 1'b1;
      tbl[i].pulse = i == 16;
      tbl[i].st    = (i >= 16 && i <= 20) ? 2'd1 : 2'd0;
    end

    for (int i = 0; i < 23; i++) begin
      cycle(tbl[i].r, tbl[i].d, tbl[i].s);
      check("tbl_up", 32'(UpOrDown), 32'(tbl[i].up));
      check("tbl_pulse", 32'(step_pulse), 32'(tbl[i].pulse));
      check("tbl_state", 32'(step_state), 32'(tbl[i].st));
    end

    np = 0;
    for (int i = 0; i < 18; i++) begin
      cycle(1'b1, 1'b0, i < 10 ? 1'((i + 1) % 2) : 1'b0);
      if (step_pulse === 1'b1 || step_state !== 2'd0) np++;
    end
    check("bounce_activity", 32'(np), 32'd0);

    got.delete();
    for (int i = 0; i < 45; i++) begin
      cycle(1'b1, 1'b0, i < 30);
      if (step_pulse === 1'b1) got.push_back(i);
    end
    exp_q.delete();
    exp_q.push_back(D + 2);
    for (o = D + 2 + H; o <= 30 + D + 1; o += R) exp_q.push_back(o);
    check("repeat_count", 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) check("repeat_edge", 32'(got[i]), 32'(exp_q[i]));

    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    check("counter_start", 32'(cnt4), 32'd0);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, i < 6, i < 6);
      if (i == D + 2) begin
        check("coincident_pulse", 32'(step_pulse), 32'd1);
        check("coincident_dir", 32'(UpOrDown), 32'd0);
      end
    end
    check("counter_wrap_down", 32'(cnt4), 32'd15);

    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b1);
    check("in_repeat", 32'(step_state), 32'd2);
    cycle(1'b0, 1'b0, 1'b1);
    check("rst_pulse", 32'(step_pulse), 32'd0);
    check("rst_state", 32'(step_state), 32'd0);
    first = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 1'b1);
      if (step_pulse === 1'b1 && first < 0) first = i;
    end
    check("rst_repulse_edge", 32'(first), 32'(D + 2));
    check("rst_dir", 32'(UpOrDown), 32'd1);

    for (int seg = 0; seg < 400; seg++) begin
      rd  = 1'($urandom_range(0, 1));
      rs  = 1'($urandom_range(0, 1));
      rr  = $urandom_range(0, 60) != 0;
      len = $urandom_range(0, 3) == 0 ? $urandom_range(15, 40) : $urandom_range(1, 8);
      for (int j = 0; j < len; j++) cycle(j == 0 ? rr : 1'b1, rd, rs);
    end
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
